// File: rtl/mux_2to1_chip.sv
// mux_2to1_chip: 2-to-1 selector with a zero-latency combinational output,
// a one-cycle registered copy of that output, and a saturating counter of
// select transitions.
module mux_2to1_chip #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_changes
);

    logic s_d;
    logic sel_toggled;
    logic cnt_at_max;

    // Zero-latency selection; independent of clock and reset.
    always_comb begin
        out = (s == 1'b0) ? a : b;
    end

    // A select transition is any difference between the live select and its
    // previous-cycle copy. s_d resets to 0, so a high select on the first
    // edge after reset release counts as a change.
    always_comb begin
        sel_toggled = (s != s_d);
        cnt_at_max  = &sel_changes;
    end

    // Registered copy of the mux result for timing-friendly consumers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

    // Previous-cycle select, used to detect transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d <= 1'b0;
        end else begin
            s_d <= s;
        end
    end

    // Saturating transition counter; reset has priority over a same-edge toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_changes <= '0;
        end else if (sel_toggled && !cnt_at_max) begin
            sel_changes <= sel_changes + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2to1_chip.sv
// tb_mux_2to1_chip: scoreboard bench for mux_2to1_chip. Stimulus pushes the
// hand-computed expectation into a queue; a monitor on the falling edge pops
// and compares against the DUT outputs.
module tb_mux_2to1_chip;

    typedef enum int {
        SIG_OUT1, SIG_OUTQ1, SIG_CNT1,
        SIG_CNT2,
        SIG_OUT8, SIG_OUTQ8
    } sig_e;

    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;

    // Instance 1: WIDTH=1, CNT_W=8
    logic       rst1 = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, s1 = 1'b0;
    logic       out1, out_q1;
    logic [7:0] cnt1;

    // Instance 2: WIDTH=1, CNT_W=2 (saturation)
    logic       rst2 = 1'b1;
    logic       a2 = 1'b0, b2 = 1'b1, s2 = 1'b0;
    logic       out2, out_q2;
    logic [1:0] cnt2;

    // Instance 3: WIDTH=8, CNT_W=8
    logic       rst3 = 1'b1;
    logic [7:0] a3 = 8'h00, b3 = 8'h00;
    logic       s3 = 1'b0;
    logic [7:0] out3, out_q3;
    logic [7:0] cnt3;

    mux_2to1_chip #(.WIDTH(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst1), .out(out1), .a(a1), .b(b1), .s(s1),
        .out_q(out_q1), .sel_changes(cnt1)
    );

    mux_2to1_chip #(.WIDTH(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .out(out2), .a(a2), .b(b2), .s(s2),
        .out_q(out_q2), .sel_changes(cnt2)
    );

    mux_2to1_chip #(.WIDTH(8), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst3), .out(out3), .a(a3), .b(b3), .s(s3),
        .out_q(out_q3), .sel_changes(cnt3)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Queue an expected value; the monitor checks it on the next falling edge.
    task automatic expect_val(input string name, input sig_e sig, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic av, input logic bv, input logic sv);
        rst1 = r;
        a1   = av;
        b1   = bv;
        s1   = sv;
    endtask

    // Monitor: drain every pending expectation against the settled outputs.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sig)
                SIG_OUT1:  act = {31'd0, out1};
                SIG_OUTQ1: act = {31'd0, out_q1};
                SIG_CNT1:  act = {24'd0, cnt1};
                SIG_CNT2:  act = {30'd0, cnt2};
                SIG_OUT8:  act = {24'd0, out3};
                SIG_OUTQ8: act = {24'd0, out_q3};
                default:   act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %0h expected %0h", e.name, act, e.exp);
            end
        end
    end

    // Truth table vectors: {a, b, s, expected out}
    logic [3:0] tt [8] = '{4'b0000, 4'b1001, 4'b0100, 4'b1101,
                           4'b0010, 4'b1010, 4'b0111, 4'b1111};

    initial begin
        logic cur_s;

        // Reset state with reset held on every instance
        step();
        expect_val("rst_out_q1", SIG_OUTQ1, 0);
        expect_val("rst_cnt1",   SIG_CNT1,  0);
        expect_val("rst_cnt2",   SIG_CNT2,  0);
        step();

        // Exhaustive truth table; reset stays high to show out ignores it
        for (int i = 0; i < 8; i++) begin
            logic [3:0] v;
            v = tt[i];
            apply_stimulus(1'b1, v[3], v[2], v[1]);
            expect_val($sformatf("truth_%0d%0d%0d", v[3], v[2], v[1]), SIG_OUT1, {31'd0, v[0]});
            step();
        end

        // Registered path: clean value before the edge, mux value after
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
        expect_val("out_q_before_edge", SIG_OUTQ1, 0);
        expect_val("out_comb_a",        SIG_OUT1,  1);
        step();
        expect_val("out_q_after_edge",  SIG_OUTQ1, 1);
        expect_val("cnt_no_toggle",     SIG_CNT1,  0);

        // Toggle s on 5 consecutive cycles; a=1, b=0 so out = ~s
        cur_s = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cur_s = ~cur_s;
            apply_stimulus(1'b0, 1'b1, 1'b0, cur_s);
            step();
            expect_val($sformatf("cnt_toggle_%0d", i), SIG_CNT1, i);
            expect_val($sformatf("out_q_toggle_%0d", i), SIG_OUTQ1, {31'd0, ~cur_s});
        end

        // Hold s for 3 cycles: count stays at 5
        for (int i = 0; i < 3; i++) begin
            step();
            expect_val($sformatf("cnt_hold_%0d", i), SIG_CNT1, 5);
        end

        // Clear, then reach 4: first edge after release with s=1 counts
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        step();
        expect_val("cnt_cleared", SIG_CNT1, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
        step();
        expect_val("cnt_first_edge_s1", SIG_CNT1, 1);
        cur_s = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            cur_s = ~cur_s;
            apply_stimulus(1'b0, 1'b1, 1'b0, cur_s);
            step();
            expect_val($sformatf("cnt_rebuild_%0d", i), SIG_CNT1, i);
        end
        expect_val("out_q_before_midrst", SIG_OUTQ1, 1);

        // Mid-run reset with a same-edge toggle of s: reset wins
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1);
        expect_val("out_during_rst", SIG_OUT1, 1);
        step();
        expect_val("cnt_midrst",   SIG_CNT1,  0);
        expect_val("out_q_midrst", SIG_OUTQ1, 0);
        expect_val("out_after_rst_edge", SIG_OUT1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        step();
        expect_val("cnt_after_midrst", SIG_CNT1,  1);
        expect_val("out_q_after_midrst", SIG_OUTQ1, 1);

        // Saturation on the 2-bit counter: 6 toggles -> 1,2,3,3,3,3
        rst2 = 1'b0;
        cur_s = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cur_s = ~cur_s;
            s2 = cur_s;
            step();
            expect_val($sformatf("sat_toggle_%0d", i), SIG_CNT2, (i < 3) ? i : 3);
        end

        // 8-bit data path
        rst3 = 1'b0;
        a3 = 8'hA5;
        b3 = 8'h3C;
        s3 = 1'b0;
        expect_val("w8_s0", SIG_OUT8, 32'hA5);
        step();
        expect_val("w8_q_s0", SIG_OUTQ8, 32'hA5);
        s3 = 1'b1;
        expect_val("w8_s1", SIG_OUT8, 32'h3C);
        step();
        expect_val("w8_q_s1", SIG_OUTQ8, 32'h3C);

        // Let the monitor drain, bounded to a few cycles
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
